// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_ctrl_pkg                                                     |
// | Shared ALU-control encodings, ALUOp codes and stage state type.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package alu_ctrl_pkg;

  localparam int LAT_MAX = 16;
  localparam int CNT_W   = 4;

  localparam logic [4:0] OP_AND     = 5'b00000;
  localparam logic [4:0] OP_OR      = 5'b00001;
  localparam logic [4:0] OP_ADD     = 5'b00010;
  localparam logic [4:0] OP_XOR     = 5'b00011;
  localparam logic [4:0] OP_SLL     = 5'b00100;
  localparam logic [4:0] OP_SRL     = 5'b00101;
  localparam logic [4:0] OP_SUB     = 5'b00110;
  localparam logic [4:0] OP_SRA     = 5'b00111;
  localparam logic [4:0] OP_SLT     = 5'b01000;
  localparam logic [4:0] OP_SLTU    = 5'b01001;
  localparam logic [4:0] OP_INVALID = 5'b11111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Base integer funct3 table; the shift-right entry is chosen by the caller.
  function automatic logic [4:0] base_op(input logic [2:0] funct3, input logic arith);
    case (funct3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = arith ? OP_SRA : OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_ctrl_decode                                                  |
// | Combinational ALUOp/funct3/funct7 decode to a 5-bit op select.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       funct7_0,
  output logic [4:0] op_choice,
  output logic       illegal,
  output logic       is_mul,
  output logic       is_div
);

  always_comb begin
    op_choice = OP_INVALID;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    case (alu_op)
      ALUOP_MEM:    op_choice = OP_ADD;
      ALUOP_BRANCH: op_choice = OP_SUB;
      ALUOP_RTYPE: begin
        if (funct7_0) begin
          // Without the M extension these encodings stay OP_INVALID.
          if (ENABLE_M) begin
            op_choice = {2'b10, funct3};
            is_mul    = ~funct3[2];
            is_div    = funct3[2];
          end
        end else if (!funct7_5) begin
          op_choice = base_op(funct3, 1'b0);
        end else if (funct3 == 3'b000) begin
          op_choice = OP_SUB;
        end else if (funct3 == 3'b101) begin
          op_choice = OP_SRA;
        end
      end
      default:      op_choice = base_op(funct3, funct7_5 && (funct3 == 3'b101));
    endcase
  end

  assign illegal = (op_choice == OP_INVALID);

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_ctrl_seq                                                     |
// | Registered ALU-control stage with handshake and M-op hold.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       funct7_0,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] op_choice,
  output logic       illegal,
  output logic       busy
);

  localparam logic [CNT_W-1:0] c_mul_init = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] c_div_init = (DIV_LAT > 1) ? CNT_W'(DIV_LAT - 2) : '0;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]       r_op;
  logic             r_illegal;
  logic [4:0]       w_dec_op;
  logic             w_dec_ill, w_is_mul, w_is_div;
  logic             w_accept, w_load, w_clear;

  alu_ctrl_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .funct7_0  (funct7_0),
    .op_choice (w_dec_op),
    .illegal   (w_dec_ill),
    .is_mul    (w_is_mul),
    .is_div    (w_is_div)
  );

  // out_ready -> in_ready is the only combinational input-to-output path.
  assign in_ready  = (r_state == EMPTY) || ((r_state == FULL) && out_ready);
  assign out_valid = (r_state == FULL);
  assign busy      = (r_state == WAIT);
  assign op_choice = r_op;
  assign illegal   = r_illegal;
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_cnt_nxt   = '0;
      w_clear     = 1'b1;
    end else if (w_accept) begin
      w_load = 1'b1;
      if (w_is_mul && (MUL_LAT > 1)) begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = c_mul_init;
      end else if (w_is_div && (DIV_LAT > 1)) begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = c_div_init;
      end else begin
        w_state_nxt = FULL;
        w_cnt_nxt   = '0;
      end
    end else begin
      case (r_state)
        WAIT: begin
          if (r_cnt == '0) w_state_nxt = FULL;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        FULL: begin
          if (out_ready) w_state_nxt = EMPTY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_cnt     <= '0;
      r_op      <= OP_INVALID;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_clear) begin
        r_op      <= OP_INVALID;
        r_illegal <= 1'b0;
      end else if (w_load) begin
        r_op      <= w_dec_op;
        r_illegal <= w_dec_ill;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised, registered ALU-control stage for the RISC-V core. It decodes ALUOp, funct3 and funct7 into a 5-bit ALU operation select. It adds a valid/ready handshake and a multi-cycle hold for M-extension ops, so the execute stage can stall on MUL/DIV without external sequencing. It sits between the main control decoder and the ALU/multiplier datapath.

## Interface
Parameters:
- ENABLE_M, 1: decode M-extension ops; when 0, M encodings are illegal.
- MUL_LAT, 2: cycles from accept to out_valid for MUL/MULH/MULHSU/MULHU; range 1..16.
- DIV_LAT, 8: cycles from accept to out_valid for DIV/DIVU/REM/REMU; range 1..16.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of the held op.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- funct3  in  3  instruction[14:12].
- funct7_5  in  1  instruction[30].
- funct7_0  in  1  instruction[25]; M-extension select.
- out_valid  out  1  op_choice is final and may retire.
- out_ready  in  1  downstream consumes.
- op_choice  out  5  ALU operation select.
- illegal  out  1  the held op decoded as invalid.
- busy  out  1  a multi-cycle op is in progress.

## Operation
- Encoding:
  - AND 00000, OR 00001, ADD 00010, XOR 00011, SLL 00100, SRL 00101, SUB 00110, SRA 00111, SLT 01000, SLTU 01001.
  - M ops are {2'b10, funct3}.
  - INVALID is 11111.
  - The low 4 bits of ADD, SUB, AND and OR keep the legacy 4-bit codes.
- Decode by alu_op:
  - 00: ADD.
  - 01: SUB.
  - 10 with funct7_0=1 and ENABLE_M=1: M op.
  - 10 otherwise: funct3 table. funct7_5 selects SUB for 000 and SRA for 101. funct7_5=1 with any other funct3 is INVALID.
  - 11: funct3 table, funct7_5 ignored except 101 (SRAI/SRLI); 000 is always ADD.
- INVALID sets illegal=1. It is handled as a single-cycle op.
- States:
  - EMPTY: in_ready=1, out_valid=0.
  - WAIT: in_ready=0, out_valid=0, busy=1; op_choice held.
  - FULL: out_valid=1; in_ready=out_ready.
- Accept is in_valid & in_ready. On accept:
  - Single-cycle op or LAT=1: go to FULL.
  - M op with LAT>1: go to WAIT, cnt=LAT-2.
- WAIT: cnt decrements each cycle; at cnt==0 go to FULL.
- FULL with out_ready: a simultaneous accept loads the new op (back-to-back, no bubble); otherwise go to EMPTY.
- flush: go to EMPTY, cnt=0, busy=0. flush has priority over accept and out_ready; an in_valid in the flush cycle is dropped.
- Reset: state EMPTY, op_choice=11111, illegal=0, busy=0, out_valid=0, cnt=0.

## Timing
- Single-cycle op accepted at edge N: out_valid high from N+1.
- M op: out_valid high from N+MUL_LAT or N+DIV_LAT. busy is high for cycles N+1 .. N+LAT-1.
- Sustained throughput for single-cycle ops is 1 per cycle.
- There is a combinational path out_ready -> in_ready; it is the only such path.
- op_choice and illegal change only on accept, reset or flush. They are stable while out_valid=0 in WAIT and while FULL stalls.
- Reset asserted mid-WAIT clears all state immediately. Operation resumes on the first edge after deassertion.

## Structure
- Package alu_ctrl_pkg holds:
  - the 5-bit op encodings, including OP_INVALID;
  - the ALUOP_* constants;
  - the state enum {EMPTY, WAIT, FULL};
  - the latency bound of 16.
- Sub-module alu_ctrl_decode is purely combinational: alu_op, funct3, funct7 bits and ENABLE_M in; op_choice, illegal and is_mul/is_div out.
- The top holds the FSM, the 4-bit down-counter and the output registers.

## Test plan
- Reset with in_valid=1: all outputs at reset values. First accept occurs on the first edge after rst_n rises.
- alu_op=10, funct3=000, funct7_5=1, out_ready=1: op_choice=00110 one cycle after accept. Streaming ADD/SUB/AND/OR gives 1 op/cycle.
- alu_op=10, funct7_0=1, funct3=100 (DIV), DIV_LAT=8: busy for 7 cycles, in_ready=0 throughout, op_choice=10100, out_valid 8 cycles after accept.
- Same DIV stimulus with ENABLE_M=0: op_choice=11111, illegal=1, out_valid after 1 cycle.
- FULL with out_ready=0 for 3 cycles: op_choice stable and in_ready=0. Release with in_valid=1 and a new op: both handshakes in one cycle, new op visible next cycle.
- flush during WAIT (MUL, MUL_LAT=4, at cycle 2): next state EMPTY with busy=0. Async rst_n pulse mid-WAIT: immediate return to reset values.
